alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU `Operation` code produced by the ALU controller and returns the 32-bit result. It sits in the EX stage behind a valid/ready handshake, so the pipeline stalls while it is busy. Shifts iterate one bit per cycle by default. All other operations, including branch compares, complete in one cycle.

## Interface
- `DATA_W`, 32: operand and result width; fixed at 32 for RV32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `operation` in 4: ALU operation code from the ALU controller.
- `src_a` in DATA_W: operand A.
- `src_b` in DATA_W: operand B; bits [4:0] are the shift amount.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out DATA_W: registered result.
- `busy` out 1: high in SHIFT or DONE.

## Operation
Operation codes, stored as `src_a` op `src_b`:
- 0000 AND.
- 0001 OR.
- 0010 ADD.
- 0011 XOR.
- 0100 SLL.
- 0101 SRL.
- 0110 SUB.
- 0111 SRA.
- 1000 BEQ: result 1 if equal.
- 1001 BLT: result 1 if A < B, signed.
- 1010 BGE: result 1 if A ≥ B, signed.
- 1011 BNE: result 1 if not equal.
- 1100 SLT: result 1 if A < B, signed.
- 1101: pass `src_b`, used for JAL/LUI.
- 1110 and 1111: result 0.

Arithmetic rules:
- Add and sub are modulo 2^32; no flags.
- Compare results are zero-extended to 32 bits.

State machine (IDLE, SHIFT, DONE):
- **IDLE:**
  - Accept occurs when `in_valid && in_ready`.
  - Non-shift op: latch the computed value into `result`, go to DONE.
  - Shift op with shamt 0: `result = src_a`, go to DONE.
  - Shift op with shamt n > 0: load the shift register with `src_a` and the count with n, go to SHIFT.
- **SHIFT:**
  - Each cycle shift by 1 (SRA replicates bit 31) and decrement the count.
  - When the count reaches 0 after the update, go to DONE.
  - `in_valid` is ignored.
- **DONE:**
  - `out_valid = 1`; `result` is held stable.
  - When `out_ready = 1`, go to IDLE.
  - `in_valid` is ignored.

Reset (asynchronous):
- State goes to IDLE, the count to 0, `result` to 0.
- `out_valid = 0`, `busy = 0`, `in_ready = 1`.
- Reset aborts any in-flight shift; no partial result is ever presented.

## Timing
- Accept at cycle t: non-shift op and shift with shamt 0 → `out_valid` at t+1.
- Shift with shamt n > 0 → `out_valid` at t+1+n; maximum t+32 for shamt 31.
- Output handshake at cycle u → `in_ready` high at u+1.
- There is no accept in the same cycle as an output handshake.
- Back-to-back single-cycle ops: one result every 2 cycles.
- `in_ready`, `out_valid` and `busy` decode directly from state registers; they have no combinational path from any input.
- `out_ready` held low: stay in DONE indefinitely with `result` unchanged.
- Operands are sampled only at accept; later changes on `src_a`/`src_b` have no effect.

## Configuration
- `ALU_EXEC_FAST_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter with latency 1, like all other ops.
  - SHIFT state and shift counter are not built.
- Undefined (default): iterative shifter, latency 1 + shamt.
- Results are bit-identical in both builds.

## Structure
- Package `alu_exec_pkg`:
  - `alu_op_t` enum holding the 16 codes.
  - `exec_state_t` enum (IDLE, SHIFT, DONE).
  - `DATA_W` and `SHAMT_W` = 5.
  - Helper `is_shift(alu_op_t)`.
- Sub-module `alu_exec_shifter` holds the shift register, counter and direction/arithmetic control.
  - Instantiated only when `ALU_EXEC_FAST_SHIFT_EN` is undefined.
  - Interface: `load`, `dir`, `arith`, `shamt`, `data_in`, `data_out`, `done`.
- The combinational op datapath and the FSM live in the top module.

## Test plan
- ADD 5+7, `out_ready=1` → `out_valid` at t+1, `result=12`; `in_ready` high at t+2.
- SUB 3−5 → `0xFFFFFFFE`; AND/OR/XOR on `0xF0F0F0F0`/`0x0FF00FF0` → `0x00F000F0`/`0xFFF0FFF0`/`0xFF00FF00`.
- SRA `0x80000000` by 4 → `0xF8000000` at t+5 (t+1 with macro); SRL same → `0x08000000`; SLL 1 by 31 → `0x80000000` at t+32; shamt 0 → `src_a` at t+1.
- Compares with A=`0xFFFFFFFF`, B=1:
  - BLT=1, BGE=0, SLT=1, BEQ=0, BNE=1.
  - A=B=7: BEQ=1, BNE=0, BGE=1.
- Backpressure: `out_ready` low 3 cycles with `in_valid` high and a new op → `result` stable, `in_ready=0`, new op not accepted until after handshake.
- SLL by 20, `reset` pulsed at t+5 → `out_valid=0`, `result=0`, `in_ready=1` immediately; next ADD completes normally with no stale output.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types for the multi-cycle execute unit.
// Holds the ALU op codes, FSM states, widths and the is_shift helper.
package alu_exec_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_BEQ   = 4'b1000,
    OP_BLT   = 4'b1001,
    OP_BGE   = 4'b1010,
    OP_BNE   = 4'b1011,
    OP_SLT   = 4'b1100,
    OP_PASSB = 4'b1101,
    OP_ZERO0 = 4'b1110,
    OP_ZERO1 = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) ||
           (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// alu_exec_shifter: iterative one-bit-per-cycle shifter.
// Ports: clk, reset (async high); load captures data_in, shamt,
// dir (1 = right) and arith (1 = SRA); data_out is the value the
// register takes on this edge; done marks the final step.
module alu_exec_shifter
  import alu_exec_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dir,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               done
);

  logic [DATA_W-1:0]  sreg;
  logic [SHAMT_W-1:0] count;
  logic               dir_q;
  logic               arith_q;
  logic               fill;

  assign fill = arith_q & sreg[DATA_W-1];

  assign data_out = dir_q
    ? {fill, sreg[DATA_W-1:1]}
    : {sreg[DATA_W-2:0], 1'b0};

  // Count hits zero on this edge, so the owner can
  // capture data_out and leave SHIFT without a spare cycle.
  assign done = (count == SHAMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      count   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      sreg    <= data_in;
      count   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (count != '0) begin
      sreg  <= data_out;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with valid/ready handshakes.
// Ports: clk, reset (async high); in_valid/in_ready, operation,
// src_a, src_b accept work; out_valid/out_ready, result return it;
// busy flags SHIFT or DONE. Define ALU_EXEC_FAST_SHIFT_EN for a
// single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  alu_op_t            op;
  logic [SHAMT_W-1:0] shamt;
  exec_state_t        state_q;
  exec_state_t        state_d;
  logic [DATA_W-1:0]  alu_val;
  logic [DATA_W-1:0]  result_q;
  logic               accept;
  logic               iter_shift;

  assign op     = alu_op_t'(operation);
  assign shamt  = src_b[SHAMT_W-1:0];
  assign accept = (state_q == IDLE) && in_valid;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign iter_shift = 1'b0;
`else
  logic [DATA_W-1:0] shift_out;
  logic              shift_done;

  assign iter_shift = is_shift(op) && (shamt != '0);

  alu_exec_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && iter_shift),
    .dir      ((op == OP_SRL) || (op == OP_SRA)),
    .arith    (op == OP_SRA),
    .shamt    (shamt),
    .data_in  (src_a),
    .data_out (shift_out),
    .done     (shift_done)
  );
`endif

  always_comb begin
    alu_val = '0;
    unique case (op)
      OP_AND:   alu_val = src_a & src_b;
      OP_OR:    alu_val = src_a | src_b;
      OP_ADD:   alu_val = src_a + src_b;
      OP_XOR:   alu_val = src_a ^ src_b;
      OP_SUB:   alu_val = src_a - src_b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      OP_SLL:   alu_val = src_a << shamt;
      OP_SRL:   alu_val = src_a >> shamt;
      OP_SRA:
        alu_val = DATA_W'($signed(src_a) >>> shamt);
`else
      // Only reached with shamt 0; longer shifts iterate.
      OP_SLL,
      OP_SRL,
      OP_SRA:   alu_val = src_a;
`endif
      OP_BEQ:   alu_val = DATA_W'(src_a == src_b);
      OP_BNE:   alu_val = DATA_W'(src_a != src_b);
      OP_BLT,
      OP_SLT:
        alu_val = DATA_W'($signed(src_a) < $signed(src_b));
      OP_BGE:
        alu_val = DATA_W'($signed(src_a) >= $signed(src_b));
      OP_PASSB: alu_val = src_b;
      OP_ZERO0,
      OP_ZERO1: alu_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (in_valid) begin
          state_d = iter_shift ? SHIFT : DONE;
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
      SHIFT:
        if (shift_done) begin
          state_d = DONE;
        end
`endif
      DONE:
        if (out_ready) begin
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if (accept && !iter_shift) begin
      result_q <= alu_val;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    end else if (state_q == SHIFT && shift_done) begin
      result_q <= shift_out;
`endif
    end
  end

  assign result    = result_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized + directed bench for alu_exec_unit.
// A spec-level model predicts result, latency and handshake flags.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit force_high = 1'b1;
  bit force_low  = 1'b0;

  bit          active    = 1'b0;
  bit          held_zero = 1'b1;
  int          t_acc     = 0;
  int          exp_lat   = 1;
  logic [31:0] exp_res   = '0;

  alu_exec_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int unsigned sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a << sh;
      4'd5:  return a >> sh;
      4'd6:  return a - b;
      4'd7:  return sa >>> sh;
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(
    input logic [3:0]  op,
    input logic [31:0] b
  );
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 1;
`else
    if (op == 4'd4 || op == 4'd5 || op == 4'd7)
      return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  // Flags packed as {in_ready, out_valid, busy}.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_flags",
          32'({in_ready, out_valid, busy}), 32'b100);
      chk("reset_result", result, 32'd0);
      active    = 1'b0;
      held_zero = 1'b1;
    end else if (!active) begin
      chk("idle_flags",
          32'({in_ready, out_valid, busy}), 32'b100);
      if (held_zero)
        chk("idle_result_zero", result, 32'd0);
      if (in_valid) begin
        active    = 1'b1;
        held_zero = 1'b0;
        t_acc     = cyc;
        exp_res   = model(operation, src_a, src_b);
        exp_lat   = lat_of(operation, src_b);
      end
    end else if (cyc < t_acc + exp_lat) begin
      chk("shift_flags",
          32'({in_ready, out_valid, busy}), 32'b001);
    end else begin
      chk("done_flags",
          32'({in_ready, out_valid, busy}), 32'b011);
      chk("result", result, exp_res);
      if (out_ready)
        active = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (force_low)
      out_ready = 1'b0;
    else if (force_high)
      out_ready = 1'b1;
    else
      out_ready = ($urandom % 3) != 0;
  end

  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n = 0;
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready low %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (active && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still busy after %0d", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    operation = 4'd0;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b0;

    chk("pin_add", model(4'd2, 32'd5, 32'd7), 32'd12);
    chk("pin_sub", model(4'd6, 32'd3, 32'd5), 32'hFFFFFFFE);
    chk("pin_and", model(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0),
        32'h00F000F0);
    chk("pin_or", model(4'd1, 32'hF0F0F0F0, 32'h0FF00FF0),
        32'hFFF0FFF0);
    chk("pin_xor", model(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0),
        32'hFF00FF00);
    chk("pin_sra", model(4'd7, 32'h80000000, 32'd4),
        32'hF8000000);
    chk("pin_srl", model(4'd5, 32'h80000000, 32'd4),
        32'h08000000);
    chk("pin_sll", model(4'd4, 32'd1, 32'd31), 32'h80000000);
    chk("pin_blt", model(4'd9, 32'hFFFFFFFF, 32'd1), 32'd1);
    chk("pin_bge", model(4'd10, 32'hFFFFFFFF, 32'd1), 32'd0);
    chk("pin_slt", model(4'd12, 32'hFFFFFFFF, 32'd1), 32'd1);
    chk("pin_beq", model(4'd8, 32'hFFFFFFFF, 32'd1), 32'd0);
    chk("pin_bne", model(4'd11, 32'hFFFFFFFF, 32'd1), 32'd1);
    chk("pin_beq_eq", model(4'd8, 32'd7, 32'd7), 32'd1);
    chk("pin_bne_eq", model(4'd11, 32'd7, 32'd7), 32'd0);
    chk("pin_bge_eq", model(4'd10, 32'd7, 32'd7), 32'd1);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    chk("pin_lat_sra4", lat_of(4'd7, 32'd4), 32'd1);
`else
    chk("pin_lat_sra4", lat_of(4'd7, 32'd4), 32'd5);
    chk("pin_lat_sll31", lat_of(4'd4, 32'd31), 32'd32);
`endif

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(4'd2, 32'd5, 32'd7);
    issue(4'd6, 32'd3, 32'd5);
    issue(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    issue(4'd1, 32'hF0F0F0F0, 32'h0FF00FF0);
    issue(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0);
    issue(4'd7, 32'h80000000, 32'd4);
    issue(4'd5, 32'h80000000, 32'd4);
    issue(4'd4, 32'd1, 32'd31);
    issue(4'd4, 32'h12345678, 32'd32);
    issue(4'd9, 32'hFFFFFFFF, 32'd1);
    issue(4'd10, 32'hFFFFFFFF, 32'd1);
    issue(4'd12, 32'hFFFFFFFF, 32'd1);
    issue(4'd8, 32'hFFFFFFFF, 32'd1);
    issue(4'd11, 32'hFFFFFFFF, 32'd1);
    issue(4'd8, 32'd7, 32'd7);
    issue(4'd11, 32'd7, 32'd7);
    issue(4'd10, 32'd7, 32'd7);
    issue(4'd13, 32'd9, 32'hABCD0000);
    drain();

    force_low = 1'b1;
    issue(4'd2, 32'd100, 32'd23);
    in_valid  = 1'b1;
    operation = 4'd6;
    src_a     = 32'd50;
    src_b     = 32'd8;
    repeat (4) @(posedge clk);
    #1;
    force_low = 1'b0;
    issue(4'd6, 32'd50, 32'd8);
    drain();

    issue(4'd4, 32'h3, 32'd20);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(4'd2, 32'd1, 32'd2);
    drain();

    force_high = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom % 2) ? $urandom : ($urandom % 8);
      if ($urandom % 4 == 0)
        a = b;
      repeat ($urandom % 3) begin
        in_valid = ($urandom % 4) == 0;
        @(posedge clk);
        #1;
      end
      issue(4'($urandom), a, b);
    end
    force_high = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
